wb_register_file: RTL

//   Architectural integer register file. It is the receiving end of the write-back interface.
//   - Write side: consumes the final result, write enable and destination index driven by the

---
 rtl/wb_register_file_if.sv | 27 ++
 rtl/wb_register_file.sv | 67 ++++++
 2 files changed

// File: rtl/wb_register_file_if.sv
// Write-back to register-file bus: one retiring write plus decode and debug reads.
// Handshake: wb_we acts as a valid with no ready; the register file always accepts the write on the clock edge where wb_we=1.
interface wb_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  modport master (
    output wb_we, wb_rd, wb_result, id_rs1, id_rs2, dbg_addr,
    input  id_rd1, id_rd2, dbg_data, wr_count
  );

  modport slave (
    input  wb_we, wb_rd, wb_result, id_rs1, id_rs2, dbg_addr,
    output id_rd1, id_rd2, dbg_data, wr_count
  );
endinterface

// File: rtl/wb_register_file.sv
// Architectural integer register file: flop array, x0 hardwired to zero, optional
// write-through bypass on the two decode read ports, debug read and saturating write counter.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    wb_register_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [15:0]       wr_count_q;
    logic              wr_commit;

    // Writes to x0 are dropped here so they never touch storage or the counter.
    assign wr_commit = bus.wb_we && (bus.wb_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[bus.wb_rd] <= bus.wb_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else if (wr_commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // Bypass only on commit, so an x0 write can never leak onto a read of index 0.
    always_comb begin
        bus.id_rd1 = '0;
        bus.id_rd2 = '0;
        if (bus.id_rs1 != '0) begin
            if (BYPASS && wr_commit && (bus.wb_rd == bus.id_rs1)) begin
                bus.id_rd1 = bus.wb_result;
            end else begin
                bus.id_rd1 = mem[bus.id_rs1];
            end
        end
        if (bus.id_rs2 != '0) begin
            if (BYPASS && wr_commit && (bus.wb_rd == bus.id_rs2)) begin
                bus.id_rd2 = bus.wb_result;
            end else begin
                bus.id_rd2 = mem[bus.id_rs2];
            end
        end
    end

    always_comb begin
        bus.dbg_data = '0;
        if (bus.dbg_addr != '0) begin
            bus.dbg_data = mem[bus.dbg_addr];
        end
    end

    assign bus.wr_count = wr_count_q;
endmodule
